alu_cmd_queue: RTL and testbench
================================

// Module: alu_cmd_queue
// PURPOSE
//   In-order command queue directly upstream of the ALU. Accepts {opcode, A, B}
//   commands on a valid/ready interface, drops illegal opcodes, buffers legal
//   ones and presents them to the ALU with first-word-fall-through valid/ready.
//   Decouples the stimulus/bus side from ALU back-pressure.
// PARAMETERS
//   DEPTH  8  queue entries; power of 2, >= 2
//   CNT_W  $clog2(DEPTH+1)  width of occupancy count (derived, do not override)
// PORTS
//   clk         in   1      clock, rising edge
//   rst         in   1      asynchronous reset, active-high
//   flush       in   1      synchronous queue clear
//   in_valid    in   1      command valid
//   in_ready    out  1      queue can accept
//   in_opcode   in   3      alu_pkg::OPCODE_T
//   in_a        in   16     alu_pkg::OP_T operand A
//   in_b        in   16     alu_pkg::OP_T operand B
//   out_valid   out  1      head entry valid toward ALU
//   out_ready   in   1      ALU accepts head entry
//   out_opcode  out  3      head opcode (OPCODE_T)
//   out_a       out  16     head operand A
//   out_b       out  16     head operand B
//   count       out  CNT_W  stored entries, 0..DEPTH
//   illegal_op  out  1      one-cycle pulse: illegal opcode dropped
// BEHAVIOUR
// - Reset (async, rst=1): count=0, pointers=0, out_valid=0, illegal_op=0,
//   out_opcode/out_a/out_b=0. Takes effect mid-transfer; all entries lost.
// - in_ready = (count != DEPTH); combinational from count only, never from in_valid.
// - Input handshake when in_valid & in_ready. Legal opcodes: ADD=0, SUB=1,
//   PASSA=2, PASSB=3, NEGA=4. Opcodes 5..7 or any X/Z bit: handshake completes,
//   nothing stored, illegal_op=1 on the following cycle only.
// - Output handshake when out_valid & out_ready: head entry retired.
// - Latency: legal push into empty queue -> out_valid=1 next cycle; no
//   same-cycle bypass. out_valid = (count != 0).
// - out_opcode/out_a/out_b driven from head entry; stable while
//   out_valid & !out_ready.
// - Simultaneous push+pop (0 < count < DEPTH): count unchanged, both pointers
//   advance. When full, in_ready=0, so no push even if a pop occurs that cycle.
// - Pointers wrap modulo DEPTH; count distinguishes full from empty.
// - flush=1: next cycle count=0, pointers=0, out_valid=0; flush overrides any
//   push/pop in that cycle. An illegal opcode presented with flush still pulses
//   illegal_op.
// - No overflow/underflow possible by construction; pushes with in_ready=0 ignored.
// CONFIGURATION
//   ALU_CMD_QUEUE_STATS_EN defined: adds ports
//     stat_accepted out 16  legal commands stored (saturates at 16'hFFFF)
//     stat_dropped  out 16  illegal commands dropped (saturates at 16'hFFFF)
//   Counters reset to 0 by rst only; flush does not clear them.
//   Not defined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset: assert rst mid-stream with count=3 -> count=0, out_valid=0,
//   in_ready=1 immediately, no retire on the next cycle.
// - Fill/drain: out_ready=0, push 8 ADD cmds (a=i, b=2*i) -> count=8, in_ready=0;
//   9th push refused; set out_ready=1 -> 8 entries out in order, a=0..7.
// - Illegal op: push opcode 3'd6 then SUB a=16'h0010 b=16'h0001 -> illegal_op
//   pulses once, count=1, head=SUB 0010/0001.
// - Concurrent: count=4, in_valid=out_ready=1 for 10 cycles -> count stays 4,
//   output order = input order, pointers wrap without loss.
// - Flush: count=5 with push+pop in same cycle as flush=1 -> next cycle count=0,
//   out_valid=0; the pushed entry is not stored.
// - Stats (ALU_CMD_QUEUE_STATS_EN): 3 legal + 2 illegal + flush ->
//   stat_accepted=3, stat_dropped=2; force 70000 legal pushes -> 16'hFFFF.

Source files
------------

// File: rtl/alu_cmd_queue.sv
// In-order command queue ahead of the ALU: drops illegal opcodes, buffers legal
// commands and presents the head first-word-fall-through. Optional `ALU_CMD_QUEUE_STATS_EN`.
module alu_cmd_queue #(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_opcode,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_opcode,
  output logic [15:0]      out_a,
  output logic [15:0]      out_b,
  output logic [CNT_W-1:0] count,
  output logic             illegal_op
`ifdef ALU_CMD_QUEUE_STATS_EN
  ,
  output logic [15:0]      stat_accepted,
  output logic [15:0]      stat_dropped
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [34:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             legal;
  logic             in_fire;
  logic             wr_en;
  logic             rd_en;
  logic             drop;
  logic [34:0]      head;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, and in_ready depends on count alone.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);

  // Unknown opcode bits fall to the default arm and are treated as illegal.
  always_comb begin
    legal = 1'b0;
    case (in_opcode)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: legal = 1'b1;
      default:                      legal = 1'b0;
    endcase
  end

  assign in_fire = in_valid & in_ready;
  assign wr_en   = in_fire & legal & ~flush;
  assign rd_en   = out_valid & out_ready & ~flush;
  assign drop    = in_fire & ~legal;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {in_opcode, in_a, in_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      illegal_op <= 1'b0;
    end else begin
      // A drop is reported even in a flush cycle.
      illegal_op <= drop;
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({wr_en, rd_en})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign head       = out_valid ? mem[rd_ptr] : '0;
  assign out_opcode = head[34:32];
  assign out_a      = head[31:16];
  assign out_b      = head[15:0];

`ifdef ALU_CMD_QUEUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_accepted <= '0;
      stat_dropped  <= '0;
    end else begin
      if (wr_en && stat_accepted != 16'hFFFF) stat_accepted <= stat_accepted + 16'd1;
      if (drop && stat_dropped != 16'hFFFF)   stat_dropped  <= stat_dropped + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Bench for alu_cmd_queue: queue-based reference model checked every cycle plus
// directed vectors with literal expectations.
module tb_alu_cmd_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_opcode;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_opcode;
  logic [15:0]      out_a;
  logic [15:0]      out_b;
  logic [CNT_W-1:0] count;
  logic             illegal_op;
`ifdef ALU_CMD_QUEUE_STATS_EN
  logic [15:0]      stat_accepted;
  logic [15:0]      stat_dropped;
`endif

  int tests_run = 0;
  int failures  = 0;

  // Reference model: a plain queue of {opcode, a, b}.
  logic [34:0] exp_q[$];
  logic        exp_illegal = 1'b0;

  alu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_a      (out_a),
    .out_b      (out_b),
    .count      (count),
    .illegal_op (illegal_op)
`ifdef ALU_CMD_QUEUE_STATS_EN
    ,
    .stat_accepted (stat_accepted),
    .stat_dropped  (stat_dropped)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge from the stimulus, then compare once outputs settle.
  always @(posedge clk) begin
    logic rdy_m;
    logic legal_m;
    logic fire_m;
    if (rst) begin
      exp_q.delete();
      exp_illegal = 1'b0;
    end else begin
      rdy_m   = (exp_q.size() != DEPTH);
      legal_m = !$isunknown(in_opcode) && (in_opcode <= 3'd4);
      fire_m  = in_valid && rdy_m;
      exp_illegal = fire_m && !legal_m;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (fire_m && legal_m) exp_q.push_back({in_opcode, in_a, in_b});
      end
    end
    #2;
    check("count",      36'(count),      36'(exp_q.size()));
    check("out_valid",  36'(out_valid),  36'(exp_q.size() != 0));
    check("in_ready",   36'(in_ready),   36'(exp_q.size() != DEPTH));
    check("illegal_op", 36'(illegal_op), 36'(exp_illegal));
    if (exp_q.size() != 0) check("head", {1'b0, out_opcode, out_a, out_b}, {1'b0, exp_q[0]});
  end

  // Driver: apply one cycle of inputs, return at the next falling edge.
  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic ordy, input logic fl);
    in_valid  = v;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 3'd0, 16'h0, 16'h0, ordy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_opcode = 3'd0;
    in_a = 16'h0; in_b = 16'h0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_count",     36'(count),      36'd0);
    check("rst_out_valid", 36'(out_valid),  36'd0);
    check("rst_in_ready",  36'(in_ready),   36'd1);
    check("rst_out_a",     36'(out_a),      36'd0);
    check("rst_illegal",   36'(illegal_op), 36'd0);
    rst = 1'b0;
    @(negedge clk);

    // Asynchronous reset with three entries held
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd1, 16'(i + 16'h100), 16'h5, 1'b0, 1'b0);
    check("pre_rst_count", 36'(count), 36'd3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_count",    36'(count),     36'd0);
    check("async_rst_outvalid", 36'(out_valid), 36'd0);
    check("async_rst_in_ready", 36'(in_ready),  36'd1);
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1);
    check("post_rst_no_retire", 36'(out_valid), 36'd0);

    // Fill, refuse the ninth push, then drain in order
    for (int i = 0; i < 8; i++) drive(1'b1, 3'd0, 16'(i), 16'(2 * i), 1'b0, 1'b0);
    check("full_count",    36'(count),    36'd8);
    check("full_in_ready", 36'(in_ready), 36'd0);
    drive(1'b1, 3'd0, 16'd99, 16'd198, 1'b0, 1'b0);
    check("ninth_refused", 36'(count), 36'd8);
    for (int i = 0; i < 8; i++) begin
      check("drain_a", 36'(out_a), 36'(i));
      check("drain_b", 36'(out_b), 36'(2 * i));
      idle(1'b1);
    end
    check("drained_count", 36'(count), 36'd0);

    // Illegal opcode dropped, following SUB stored
    drive(1'b1, 3'd6, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
    check("illegal_pulse", 36'(illegal_op), 36'd1);
    check("illegal_nostore", 36'(count), 36'd0);
    drive(1'b1, 3'd1, 16'h0010, 16'h0001, 1'b0, 1'b0);
    check("illegal_once",  36'(illegal_op), 36'd0);
    check("sub_count",     36'(count),      36'd1);
    check("sub_head",      {1'b0, out_opcode, out_a, out_b}, {1'b0, 3'd1, 16'h0010, 16'h0001});

    // Concurrent push and pop at count 4 across a pointer wrap
    for (int i = 0; i < 3; i++) drive(1'b1, 3'(i + 2), 16'(16'h200 + i), 16'(16'h300 + i), 1'b0, 1'b0);
    check("conc_start", 36'(count), 36'd4);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'(i % 5), 16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)), 1'b1, 1'b0);
      check("conc_count", 36'(count), 36'd4);
    end

    // Flush beats simultaneous push and pop
    drive(1'b1, 3'd2, 16'h0AAA, 16'h0BBB, 1'b0, 1'b0);
    check("pre_flush_count", 36'(count), 36'd5);
    drive(1'b1, 3'd0, 16'h1234, 16'h5678, 1'b1, 1'b1);
    check("flush_count",     36'(count),     36'd0);
    check("flush_out_valid", 36'(out_valid), 36'd0);
    idle(1'b1);
    check("flush_nostore",   36'(count), 36'd0);
    drive(1'b1, 3'd7, 16'h0, 16'h0, 1'b0, 1'b1);
    check("flush_illegal",   36'(illegal_op), 36'd1);
    idle(1'b0);

`ifdef ALU_CMD_QUEUE_STATS_EN
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd0, 16'(i), 16'(i), 1'b0, 1'b0);
    drive(1'b1, 3'd5, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 3'd7, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b1);
    idle(1'b0);
    check("stat_accepted", 36'(stat_accepted), 36'd3);
    check("stat_dropped",  36'(stat_dropped),  36'd2);
    for (int i = 0; i < 65540; i++) drive(1'b1, 3'd0, 16'(i), 16'h1, 1'b1, 1'b0);
    idle(1'b1);
    check("stat_accepted_sat", 36'(stat_accepted), 36'h0FFFF);
    check("stat_dropped_hold", 36'(stat_dropped),  36'd2);
`endif

    repeat (2) idle(1'b1);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
